// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
//
// Parametrised SPI master: DATA_W-bit words MSB first, SCK half-period of DIV
// CLK cycles, NUM_CS one-hot active-low chip selects, all four CKP/CPH modes
// chosen per transfer. The received word is published on a one-cycle DONE.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-low reset
//   START_STB  start request, sampled only while idle
//   TX_DATA    word to send, latched at start
//   CS_SEL     target index, latched at start
//   CKP, CPH   clock polarity / phase, latched at start
//   MISO       serial data from target
//   SCK, MOSI  serial clock / data to target
//   CS_N       active-low chip selects
//   BUSY       transfer in progress
//   DONE       one-cycle end-of-transfer pulse
//   RX_DATA    last received word, updated with DONE
//   ERR        one-cycle pulse for a start with an out-of-range CS_SEL
// -----------------------------------------------------------------------------
module spi_master_param #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DIV    = 2,
   parameter int unsigned NUM_CS = 2,
   parameter int unsigned SEL_W  = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START_STB,
   input  logic [DATA_W-1:0] TX_DATA,
   input  logic [SEL_W-1:0]  CS_SEL,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              MISO,
   output logic              SCK,
   output logic              MOSI,
   output logic [NUM_CS-1:0] CS_N,
   output logic              BUSY,
   output logic              DONE,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              ERR
);

   localparam int unsigned DIV_CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned EDGE_CW = $clog2(2 * DATA_W + 1);
   localparam logic [DIV_CW-1:0]  DIV_LAST  = DIV_CW'(DIV - 1);
   localparam logic [EDGE_CW-1:0] EDGE_LAST = EDGE_CW'(2 * DATA_W);

   typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

   state_e              state_q, state_d;
   logic [DIV_CW-1:0]   div_q, div_d;
   logic [EDGE_CW-1:0]  edge_q, edge_d;
   logic [EDGE_CW-1:0]  edge_num;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                cph_q, cph_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                sel_valid;
   logic                do_edge;

   assign sel_valid = (32'(CS_SEL) < NUM_CS);
   // edge_q counts SCK edges already issued; edge_num is the one about to fire
   assign edge_num  = edge_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      edge_d    = edge_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cph_d     = cph_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      do_edge   = 1'b0;

      unique case (state_q)
         StIdle: begin
            sck_d = CKP;
            if (START_STB) begin
               if (sel_valid) begin
                  state_d = StSetup;
                  div_d   = '0;
                  edge_d  = '0;
                  busy_d  = 1'b1;
                  cs_n_d  = ~(NUM_CS'(1) << CS_SEL);
                  cph_d   = CPH;
                  tx_sh_d = TX_DATA;
                  rx_sh_d = '0;
                  // CPH=1 leaves MOSI untouched until the first SCK edge
                  if (!CPH) begin
                     mosi_d = TX_DATA[DATA_W-1];
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StSetup, StXfer: begin
            if (div_q == DIV_LAST) begin
               do_edge = 1'b1;
               div_d   = '0;
               if (edge_num == EDGE_LAST) begin
                  state_d = StHold;
                  edge_d  = '0;
               end else begin
                  state_d = StXfer;
                  edge_d  = edge_num;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StHold: begin
            if (div_q == DIV_LAST) begin
               state_d   = StIdle;
               div_d     = '0;
               edge_d    = '0;
               cs_n_d    = '1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (do_edge) begin
         sck_d = ~sck_q;
         if (edge_num[0]) begin
            // leading edge
            if (!cph_q) begin
               rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
            end else begin
               mosi_d  = tx_sh_q[DATA_W-1];
               tx_sh_d = tx_sh_q << 1;
            end
         end else begin
            // trailing edge; in CPH=0 the final edge has no next bit to drive
            if (cph_q) begin
               rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
            end else if (edge_num != EDGE_LAST) begin
               mosi_d  = tx_sh_q[DATA_W-2];
               tx_sh_d = tx_sh_q << 1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= StIdle;
         div_q     <= '0;
         edge_q    <= '0;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= '1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cph_q     <= 1'b0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         edge_q    <= edge_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         cph_q     <= cph_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign SCK     = sck_q;
   assign MOSI    = mosi_q;
   assign CS_N    = cs_n_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign RX_DATA = rx_data_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
//
// Directed bench for spi_master_param (DATA_W=16, DIV=2, NUM_CS=2, SEL_W=2).
// A behavioural SPI target shifts out a fixed word and captures MOSI, or MISO
// can be looped back from MOSI.
// -----------------------------------------------------------------------------
module tb_spi_master_param;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned DIV    = 2;
   localparam int unsigned NUM_CS = 2;
   localparam int unsigned SEL_W  = 2;

   logic              CLK = 1'b0;
   logic              RESET = 1'b0;
   logic              START_STB = 1'b0;
   logic [DATA_W-1:0] TX_DATA = '0;
   logic [SEL_W-1:0]  CS_SEL = '0;
   logic              CKP = 1'b0;
   logic              CPH = 1'b0;
   logic              MISO;
   logic              SCK;
   logic              MOSI;
   logic [NUM_CS-1:0] CS_N;
   logic              BUSY;
   logic              DONE;
   logic [DATA_W-1:0] RX_DATA;
   logic              ERR;

   int checks = 0;
   int errors = 0;

   // target model state
   logic              loop_en = 1'b0;
   logic              t_cph = 1'b0;
   logic [DATA_W-1:0] t_word = '0;
   logic [DATA_W-1:0] t_sh = '0;
   logic [DATA_W-1:0] t_cap = '0;
   logic              t_miso = 1'b0;
   int                t_edges = 0;
   logic [NUM_CS-1:0] cs_prev = '1;
   logic              sck_prev = 1'b0;

   assign MISO = loop_en ? MOSI : t_miso;

   spi_master_param #(
      .DATA_W(DATA_W),
      .DIV   (DIV),
      .NUM_CS(NUM_CS),
      .SEL_W (SEL_W)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START_STB(START_STB),
      .TX_DATA  (TX_DATA),
      .CS_SEL   (CS_SEL),
      .CKP      (CKP),
      .CPH      (CPH),
      .MISO     (MISO),
      .SCK      (SCK),
      .MOSI     (MOSI),
      .CS_N     (CS_N),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .RX_DATA  (RX_DATA),
      .ERR      (ERR)
   );

   always #5 CLK = ~CLK;

   // Target: odd SCK edges are leading, even are trailing, counted from CS fall.
   always @(CS_N or SCK) begin
      if (CS_N !== cs_prev) begin
         if (~&CS_N) begin
            t_sh    = t_word;
            t_miso  = t_word[DATA_W-1];
            t_cap   = '0;
            t_edges = 0;
         end
         cs_prev = CS_N;
      end
      if (SCK !== sck_prev) begin
         if (~&CS_N) begin
            t_edges = t_edges + 1;
            if (t_edges % 2 == 1) begin
               if (!t_cph) begin
                  t_cap = {t_cap[DATA_W-2:0], MOSI};
               end else begin
                  t_miso = t_sh[DATA_W-1];
                  t_sh   = t_sh << 1;
               end
            end else begin
               if (t_cph) begin
                  t_cap = {t_cap[DATA_W-2:0], MOSI};
               end else begin
                  t_sh   = t_sh << 1;
                  t_miso = t_sh[DATA_W-1];
               end
            end
         end
         sck_prev = SCK;
      end
   end

   // Runs one transfer. n is the cycle index after the accepting edge T0
   // (n=1 right after T0). Optionally pulses START_STB again at n==pulse_at
   // with altered TX_DATA/CS_SEL/CKP/CPH.
   task automatic run_xfer(input logic [DATA_W-1:0] tx, input logic [SEL_W-1:0] sel,
                           input logic ckp, input logic cph, input logic [DATA_W-1:0] word,
                           input logic lp, input int pulse_at,
                           output logic idle_sck, output logic [NUM_CS-1:0] cs_seen,
                           output logic busy_seen, output int first_n, output int done_n);
      int n;
      CKP     = ckp;
      CPH     = cph;
      t_cph   = cph;
      t_word  = word;
      loop_en = lp;
      TX_DATA = tx;
      CS_SEL  = sel;
      repeat (2) @(posedge CLK);
      #1;
      idle_sck  = SCK;
      START_STB = 1'b1;
      @(posedge CLK);
      #1;
      START_STB = 1'b0;
      n         = 1;
      cs_seen   = CS_N;
      busy_seen = BUSY;
      first_n   = 0;
      while (!DONE && n < 300) begin
         if (n == pulse_at) begin
            START_STB = 1'b1;
            TX_DATA   = ~tx;
            CS_SEL    = ~sel;
            CKP       = ~ckp;
            CPH       = ~cph;
         end else begin
            START_STB = 1'b0;
         end
         @(posedge CLK);
         #1;
         n++;
         if (first_n == 0 && SCK !== ckp) first_n = n;
      end
      START_STB = 1'b0;
      CKP       = ckp;
      CPH       = cph;
      done_n    = DONE ? n : -1;
   endtask

   task automatic test_reset;
      checks++;
      if ({SCK, MOSI, CS_N, BUSY, DONE, ERR} !== 7'b0011000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 0011000", {SCK, MOSI, CS_N, BUSY, DONE, ERR});
      end
      checks++;
      if (RX_DATA !== 16'h0000) begin
         errors++;
         $display("FAIL reset_rx got %h want 0000", RX_DATA);
      end
   endtask

   task automatic test_mode(input logic ckp, input logic cph, input logic [SEL_W-1:0] sel);
      logic idle; logic [NUM_CS-1:0] cs; logic busy; int first_n; int done_n;
      run_xfer(16'h0305, sel, ckp, cph, 16'h0601, 1'b0, 0, idle, cs, busy, first_n, done_n);
      checks++;
      if (idle !== ckp) begin
         errors++; $display("FAIL idle_sck mode%0d got %b want %b", {ckp, cph}, idle, ckp);
      end
      checks++;
      if (cs !== ~(2'b01 << sel) || busy !== 1'b1) begin
         errors++; $display("FAIL cs_busy mode%0d got %b/%b want %b/1", {ckp, cph}, cs, busy,
                            ~(2'b01 << sel));
      end
      checks++;
      if (first_n !== 3) begin
         errors++; $display("FAIL first_edge mode%0d got %0d want 3", {ckp, cph}, first_n);
      end
      checks++;
      if (done_n !== 67) begin
         errors++; $display("FAIL done_time mode%0d got %0d want 67", {ckp, cph}, done_n);
      end
      checks++;
      if (RX_DATA !== 16'h0601) begin
         errors++; $display("FAIL rx mode%0d got %h want 0601", {ckp, cph}, RX_DATA);
      end
      checks++;
      if (t_cap !== 16'h0305) begin
         errors++; $display("FAIL mosi mode%0d got %h want 0305", {ckp, cph}, t_cap);
      end
      checks++;
      if (t_edges !== 32) begin
         errors++; $display("FAIL edges mode%0d got %0d want 32", {ckp, cph}, t_edges);
      end
      checks++;
      if ({CS_N, BUSY, SCK} !== {2'b11, 1'b0, ckp}) begin
         errors++; $display("FAIL end_state mode%0d got %b want %b", {ckp, cph},
                            {CS_N, BUSY, SCK}, {2'b11, 1'b0, ckp});
      end
   endtask

   task automatic test_modes;
      for (int m = 0; m < 4; m++) begin
         test_mode((m >= 2), (m % 2 == 1), 2'd0);
      end
   endtask

   task automatic test_loopback;
      logic idle; logic [NUM_CS-1:0] cs; logic busy; int first_n; int done_n;
      run_xfer(16'hA5C3, 2'd1, 1'b0, 1'b0, 16'h0000, 1'b1, 0, idle, cs, busy, first_n, done_n);
      checks++;
      if (cs !== 2'b01) begin
         errors++; $display("FAIL loop_cs got %b want 01", cs);
      end
      checks++;
      if (RX_DATA !== 16'hA5C3 || done_n !== 67) begin
         errors++; $display("FAIL loop_rx got %h@%0d want a5c3@67", RX_DATA, done_n);
      end
      loop_en = 1'b0;
   endtask

   task automatic test_busy_ignore;
      logic idle; logic [NUM_CS-1:0] cs; logic busy; int first_n; int done_n; int extra;
      run_xfer(16'h0305, 2'd0, 1'b0, 1'b0, 16'h0601, 1'b0, 10, idle, cs, busy, first_n, done_n);
      checks++;
      if (done_n !== 67 || RX_DATA !== 16'h0601 || t_cap !== 16'h0305) begin
         errors++; $display("FAIL busy_xfer got %0d/%h/%h want 67/0601/0305", done_n, RX_DATA,
                            t_cap);
      end
      extra = 0;
      repeat (20) begin
         @(posedge CLK);
         #1;
         if (DONE || BUSY || CS_N !== 2'b11) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++; $display("FAIL busy_noqueue got %0d active cycles want 0", extra);
      end
      checks++;
      if (RX_DATA !== 16'h0601) begin
         errors++; $display("FAIL rx_hold got %h want 0601", RX_DATA);
      end
   endtask

   task automatic test_err;
      TX_DATA = 16'h1234;
      CS_SEL  = 2'd2;
      @(posedge CLK);
      #1;
      START_STB = 1'b1;
      @(posedge CLK);
      #1;
      START_STB = 1'b0;
      checks++;
      if ({ERR, BUSY, CS_N} !== 4'b1011) begin
         errors++; $display("FAIL err_pulse got %b want 1011", {ERR, BUSY, CS_N});
      end
      @(posedge CLK);
      #1;
      checks++;
      if ({ERR, BUSY, CS_N} !== 4'b0011) begin
         errors++; $display("FAIL err_after got %b want 0011", {ERR, BUSY, CS_N});
      end
      CS_SEL = 2'd0;
   endtask

   task automatic test_reset_abort;
      logic idle; logic [NUM_CS-1:0] cs; logic busy; int first_n; int done_n; int dones;
      int n;
      CKP = 1'b0; CPH = 1'b0; t_cph = 1'b0; t_word = 16'h0601;
      TX_DATA = 16'h0305; CS_SEL = 2'd0;
      repeat (2) @(posedge CLK);
      #1;
      START_STB = 1'b1;
      @(posedge CLK);
      #1;
      START_STB = 1'b0;
      n = 1;
      while (n < 20) begin
         @(posedge CLK);
         #1;
         n++;
      end
      checks++;
      if (BUSY !== 1'b1) begin
         errors++; $display("FAIL abort_pre got busy %b want 1", BUSY);
      end
      RESET = 1'b0;
      #1;
      checks++;
      if ({SCK, MOSI, CS_N, BUSY, DONE, ERR} !== 7'b0011000 || RX_DATA !== 16'h0000) begin
         errors++; $display("FAIL abort_async got %b/%h want 0011000/0000",
                            {SCK, MOSI, CS_N, BUSY, DONE, ERR}, RX_DATA);
      end
      dones = 0;
      repeat (4) begin
         @(posedge CLK);
         #1;
         if (DONE) dones++;
      end
      RESET = 1'b1;
      repeat (70) begin
         @(posedge CLK);
         #1;
         if (DONE || BUSY) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++; $display("FAIL abort_nodone got %0d want 0", dones);
      end
      run_xfer(16'h0305, 2'd0, 1'b0, 1'b0, 16'h0601, 1'b0, 0, idle, cs, busy, first_n, done_n);
      checks++;
      if (done_n !== 67 || RX_DATA !== 16'h0601 || t_cap !== 16'h0305) begin
         errors++; $display("FAIL abort_restart got %0d/%h/%h want 67/0601/0305", done_n,
                            RX_DATA, t_cap);
      end
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      test_reset();
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      test_reset();
      test_modes();
      test_loopback();
      test_busy_ignore();
      test_err();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master, the successor to the fixed 16-bit CPU-side SPI master. It has configurable word width, an SCK divider and multiple one-hot chip selects. All four CKP/CPH modes are selectable per transfer, and the received word is returned on a DONE strobe. It sits between the CPU-side control logic and one or more daisy-chained or parallel target_spi devices.

Parameters:
DATA_W, 16, bits per transfer (>=2); MSB first.
DIV, 2, CLK cycles per SCK half-period (>=1).
NUM_CS, 2, number of chip-select lines (>=1).
SEL_W, 1, width of CS_SEL (2^SEL_W >= NUM_CS).

Ports:
CLK  in  1  system clock; all logic on rising edge.
RESET  in  1  asynchronous, active-low reset.
START_STB  in  1  one-cycle (or longer) start request; sampled only in IDLE.
TX_DATA  in  DATA_W  word to transmit; latched at start.
CS_SEL  in  SEL_W  target index; latched at start.
CKP  in  1  clock polarity (SCK idle level); latched at start.
CPH  in  1  clock phase; latched at start.
MISO  in  1  serial data from target.
SCK  out  1  serial clock.
MOSI  out  1  serial data to target.
CS_N  out  NUM_CS  active-low chip selects, one-hot low during transfer.
BUSY  out  1  high from the cycle after accepted start until DONE.
DONE  out  1  one-cycle pulse at transfer end.
RX_DATA  out  DATA_W  received word; valid from DONE, held until next DONE.
ERR  out  1  one-cycle pulse when start is rejected for CS_SEL >= NUM_CS.

Behaviour:
- Reset (async, RESET=0): state=IDLE, SCK=0, MOSI=0, CS_N=all 1, BUSY=0, DONE=0, ERR=0, RX_DATA=0, shift regs/counters=0. Reset mid-transfer aborts immediately. No DONE is issued.
- State machine: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE:
  - SCK <= CKP each cycle so the idle level tracks the input.
  - START_STB=1 at edge T0 with valid CS_SEL: latch TX_DATA, CS_SEL, CKP, CPH, then go to SETUP.
  - START_STB=1 with invalid CS_SEL: ERR=1 at T0+1, stay IDLE, no CS_N activity.
- SETUP (DIV cycles):
  - From T0+1: BUSY=1, CS_N[sel]=0, SCK=latched CKP.
  - CPH=0: MOSI=TX[DATA_W-1] at T0+1.
  - CPH=1: MOSI holds its previous value until the first edge.
- XFER:
  - SCK toggles every DIV cycles. First edge at T0+1+DIV. Exactly 2*DATA_W edges; last at T0+1+2*DATA_W*DIV.
  - CPH=0: sample MISO on odd (leading) edges; shift MOSI to the next bit on even (trailing) edges, except the final edge.
  - CPH=1: drive the next MOSI bit on odd edges (first edge drives MSB); sample MISO on even edges.
  - Received bits enter at LSB, shifting left, so first sampled = RX MSB.
- HOLD (DIV cycles after last edge): SCK stays at idle level, CS_N[sel] stays low.
- End of HOLD, cycle T0+1+(2*DATA_W+1)*DIV:
  - CS_N=all 1, BUSY=0, DONE=1 for one cycle, RX_DATA updated, state=IDLE.
  - A new start is accepted in the cycle after DONE.
- START_STB while BUSY=1: ignored, no queueing. Held START_STB restarts one cycle after DONE.
- Changing CKP/CPH/TX_DATA/CS_SEL during a transfer has no effect.
- Counters: edge counter is clog2(2*DATA_W+1) bits; divider counter is clog2(DIV) bits (min 1). Both are reset at each state entry.

Test Plan:
- Mode 0 (CKP=0, CPH=0), DATA_W=16, DIV=2, CS_SEL=0, TX=0x0305, target returns 0x0601, start at T0:
  - CS_N=2'b10 at T0+1; first SCK rise at T0+3.
  - DONE at T0+67; RX_DATA=0x0601; MOSI bits captured by the target = 0x0305.
- Modes 1/2/3 with the same data:
  - Idle SCK = CKP, 32 SCK edges.
  - Sampling on the correct edge per CPH; RX_DATA=0x0601 in all modes.
- MOSI looped to MISO, TX=0xA5C3, CS_SEL=1: RX_DATA=0xA5C3; CS_N=2'b01 during the transfer.
- START_STB pulsed at T0+10 during a busy transfer: ignored; exactly one DONE at T0+67.
- CS_SEL=2 with NUM_CS=2: ERR pulse at T0+1; BUSY stays 0; CS_N stays 2'b11.
- RESET low at T0+20: all outputs return to reset values asynchronously, no DONE. A subsequent start after RESET high completes normally.
